// File: rtl/uart_rx_fifo_if.sv
// MMIO bus and receiver strobe bundle for the UART receive FIFO.
// The master side is the UART receiver plus the CPU bus; the slave side is the FIFO.
interface uart_rx_fifo_if;
  logic        rxnew;
  logic [7:0]  rxdata;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic        irq;

  modport master (
    output rxnew, rxdata, a, d, we,
    input  spo, irq
  );

  modport slave (
    input  rxnew, rxdata, a, d, we,
    output spo, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: captures every rxnew byte, exposes it on the
// byte-lane MMIO bus and raises a level interrupt at a programmable fill threshold.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [CW-1:0]         CNT_MAX = CW'(DEPTH);

  typedef enum logic [2:0] {
    A_DATA   = 3'd0,
    A_STATUS = 3'd1,
    A_COUNT  = 3'd2,
    A_CTRL   = 3'd3,
    A_THRESH = 3'd4
  } addr_e;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, thresh;
  logic                  ovf, irq_q;

  logic full, empty, pop, flush, clr_ovf, thresh_we, wr_en, ovf_set;
  logic unused_d;

  assign unused_d = ^bus.d[23:0];

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    full      = (count == CNT_MAX);
    empty     = (count == '0);
    pop       = bus.we && (bus.a == A_STATUS) && !empty;
    flush     = bus.we && (bus.a == A_CTRL) && bus.d[25];
    clr_ovf   = bus.we && (bus.a == A_CTRL) && bus.d[24];
    thresh_we = bus.we && (bus.a == A_THRESH);
    // A flush frees the whole buffer, so a push in the same cycle is always accepted.
    wr_en     = bus.rxnew && (flush || !full || pop);
    ovf_set   = bus.rxnew && full && !pop && !flush;
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.rxdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      thresh <= CNT_ONE;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;

      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= wr_en ? CNT_ONE : '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        if (wr_en && !pop)      count <= count + CNT_ONE;
        else if (pop && !wr_en) count <= count - CNT_ONE;
      end

      // A new overflow in the same cycle as a clear must not be lost.
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;

      if (thresh_we) thresh <= CW'(bus.d[31:24]);

      irq_q <= (thresh != '0) && (count >= thresh);
    end
  end

  always_comb begin
    bus.spo = '0;
    case (bus.a)
      A_DATA:   if (!empty) bus.spo[31:24] = mem[rd_ptr];
      A_STATUS: bus.spo[24] = !empty;
      A_COUNT:  bus.spo[31:24] = 8'(count);
      A_CTRL: begin
        bus.spo[24] = ovf;
        bus.spo[25] = full;
      end
      A_THRESH: bus.spo[31:24] = 8'(thresh);
      default:  bus.spo = '0;
    endcase
  end

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by random traffic,
// all compared against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  byte unsigned q[$];
  bit           m_ovf;
  int           m_thresh;
  bit           m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_ovf    = 1'b0;
    m_thresh = 1;
    m_irq    = 1'b0;
  endfunction

  task automatic rd(input logic [2:0] addr, output logic [31:0] v);
    bus.a = addr;
    #1;
    v = bus.spo;
  endtask

  task automatic expect_reg(input string tag, input logic [2:0] addr, input logic [31:0] e);
    logic [31:0] v;
    rd(addr, v);
    check(tag, v, e);
  endtask

  task automatic expect_irq(input string tag, input bit e);
    check(tag, {31'd0, bus.irq}, {31'd0, e});
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    rd(3'd0, v);
    e = (q.size() != 0) ? {q[0], 24'h0} : 32'h0;
    check({tag, ".head"}, v, e);
    rd(3'd1, v);
    check({tag, ".nempty"}, v, {7'd0, q.size() != 0, 24'd0});
    rd(3'd2, v);
    check({tag, ".count"}, v, {8'(q.size()), 24'd0});
    rd(3'd3, v);
    check({tag, ".ctrl"}, v, {6'd0, q.size() == DEPTH, m_ovf, 24'd0});
    rd(3'd4, v);
    check({tag, ".thresh"}, v, {8'(m_thresh), 24'd0});
    rd(3'($urandom_range(5, 7)), v);
    check({tag, ".unused"}, v, 32'd0);
    check({tag, ".irq"}, {31'd0, bus.irq}, {31'd0, m_irq});
  endtask

  // One clock cycle of stimulus; the model advances by the same rules at the same edge.
  task automatic tick(input bit push, input logic [7:0] val, input bit wr,
                      input logic [2:0] addr, input logic [31:0] wd);
    bit pop, flush, clr, irq_n, ovf_evt;
    bus.rxnew  = push;
    bus.rxdata = val;
    bus.we     = wr;
    bus.a      = addr;
    bus.d      = wd;

    irq_n   = (m_thresh != 0) && (q.size() >= m_thresh);
    pop     = wr && (addr == 3'd1) && (q.size() != 0);
    flush   = wr && (addr == 3'd3) && wd[25];
    clr     = wr && (addr == 3'd3) && wd[24];
    ovf_evt = 1'b0;

    if (flush)    q.delete();
    else if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(val);
      else                  ovf_evt = 1'b1;
    end
    if (ovf_evt)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (wr && (addr == 3'd4)) m_thresh = int'(wd[28:24]);
    m_irq = irq_n;

    @(posedge clk);
    #1;
    bus.rxnew = 1'b0;
    bus.we    = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] val);
    tick(1'b1, val, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic pop_b();
    tick(1'b0, 8'd0, 1'b1, 3'd1, 32'd0);
  endtask

  task automatic idle();
    tick(1'b0, 8'd0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    bus.rxnew  = 1'b0;
    bus.rxdata = 8'd0;
    bus.we     = 1'b0;
    bus.a      = 3'd0;
    bus.d      = 32'd0;
    model_reset();
    #12;
    rst_n = 1'b1;
    check_regs("reset");
    expect_reg("reset.thresh1", 3'd4, 32'h0100_0000);

    // Basic ordering and latency
    push_b(8'h41); check_regs("t1.p0");
    push_b(8'h42); check_regs("t1.p1");
    push_b(8'h43); check_regs("t1.p2");
    expect_reg("t1.count3", 3'd2, 32'h0300_0000);
    expect_reg("t1.head41", 3'd0, 32'h4100_0000);
    pop_b(); expect_reg("t1.head42", 3'd0, 32'h4200_0000);
    pop_b(); expect_reg("t1.head43", 3'd0, 32'h4300_0000);
    pop_b(); expect_reg("t1.empty", 3'd1, 32'h0);
    check_regs("t1.end");

    // Fill, overflow (with a same-cycle clear that must lose), drain in order
    for (int i = 0; i < DEPTH; i++) push_b(8'(i));
    check_regs("t2.full");
    tick(1'b1, 8'hAA, 1'b1, 3'd3, 32'h0100_0000);
    expect_reg("t2.ovf_full", 3'd3, 32'h0300_0000);
    check_regs("t2.ovf");
    for (int i = 0; i < DEPTH; i++) begin
      expect_reg("t2.drain", 3'd0, {8'(i), 24'h0});
      pop_b();
    end
    expect_reg("t2.drained", 3'd2, 32'h0);
    tick(1'b0, 8'd0, 1'b1, 3'd3, 32'h0100_0000);
    expect_reg("t2.ovf_clr", 3'd3, 32'h0);

    // Push and pop together at full, then wrap-around
    for (int i = 0; i < DEPTH; i++) push_b(8'($urandom));
    tick(1'b1, 8'h55, 1'b1, 3'd1, 32'd0);
    expect_reg("t3.count16", 3'd2, 32'h1000_0000);
    expect_reg("t3.no_ovf", 3'd3, 32'h0200_0000);
    for (int i = 0; i < DEPTH - 1; i++) pop_b();
    expect_reg("t3.head55", 3'd0, 32'h5500_0000);
    check_regs("t3.end");

    // Threshold interrupt timing
    tick(1'b0, 8'd0, 1'b1, 3'd3, 32'h0200_0000);
    tick(1'b0, 8'd0, 1'b1, 3'd4, 32'h0400_0000);
    for (int i = 0; i < 3; i++) begin
      push_b(8'h60 + 8'(i));
      expect_irq("t4.below", 1'b0);
    end
    push_b(8'h63);
    expect_irq("t4.n_plus_1", 1'b0);
    idle();
    expect_irq("t4.n_plus_2", 1'b1);
    pop_b();
    expect_irq("t4.pop_lag", 1'b1);
    idle();
    expect_irq("t4.dropped", 1'b0);
    check_regs("t4.mid");
    tick(1'b0, 8'd0, 1'b1, 3'd4, 32'h0000_0000);
    for (int i = 0; i < DEPTH; i++) begin
      push_b(8'($urandom));
      expect_irq("t4.disabled", 1'b0);
    end
    check_regs("t4.end");

    // Pop on empty, flush with simultaneous push
    tick(1'b0, 8'd0, 1'b1, 3'd3, 32'h0200_0000);
    pop_b();
    expect_reg("t5.empty_pop", 3'd2, 32'h0);
    push_b(8'h7E);
    expect_reg("t5.head7e", 3'd0, 32'h7E00_0000);
    for (int i = 0; i < 4; i++) push_b(8'h80 + 8'(i));
    expect_reg("t5.count5", 3'd2, 32'h0500_0000);
    tick(1'b1, 8'h99, 1'b1, 3'd3, 32'h0200_0000);
    expect_reg("t5.flush_count", 3'd2, 32'h0100_0000);
    expect_reg("t5.flush_head", 3'd0, 32'h9900_0000);
    check_regs("t5.end");

    // Asynchronous reset in mid-cycle
    tick(1'b0, 8'd0, 1'b1, 3'd4, 32'h0200_0000);
    for (int i = 0; i < 5; i++) push_b(8'hC0 + 8'(i));
    idle();
    expect_irq("t6.pre_irq", 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    expect_reg("t6.rst_count", 3'd2, 32'h0);
    expect_irq("t6.rst_irq", 1'b0);
    model_reset();
    bus.rxnew  = 1'b1;
    bus.rxdata = 8'hEE;
    @(posedge clk);
    #2;
    bus.rxnew = 1'b0;
    #2;
    rst_n = 1'b1;
    check_regs("t6.released");
    push_b(8'h31);
    expect_reg("t6.head31", 3'd0, 32'h3100_0000);
    expect_reg("t6.count1", 3'd2, 32'h0100_0000);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      bit push;
      logic [31:0] wd;
      r    = $urandom_range(0, 99);
      push = ($urandom_range(0, 99) < 55);
      wd   = $urandom;
      if (r < 45) begin
        tick(push, 8'($urandom), 1'b1, 3'd1, wd);
      end else if (r < 52) begin
        wd[25] = ($urandom_range(0, 9) == 0);
        tick(push, 8'($urandom), 1'b1, 3'd3, wd);
      end else if (r < 56) begin
        wd[31:24] = 8'($urandom_range(0, 20));
        tick(push, 8'($urandom), 1'b1, 3'd4, wd);
      end else if (r < 62) begin
        case ($urandom_range(0, 4))
          0:       tick(push, 8'($urandom), 1'b1, 3'd0, wd);
          1:       tick(push, 8'($urandom), 1'b1, 3'd2, wd);
          2:       tick(push, 8'($urandom), 1'b1, 3'd5, wd);
          3:       tick(push, 8'($urandom), 1'b1, 3'd6, wd);
          default: tick(push, 8'($urandom), 1'b1, 3'd7, wd);
        endcase
      end else begin
        tick(push, 8'($urandom), 1'b0, 3'd0, wd);
      end
      check_regs("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
